// File: rtl/joltage_pkg.sv
// Shared constants and types for the joltage byte-stream producer.
// Character codes, FSM states, byte classes and error bit positions.
package joltage_pkg;

  localparam int JW = 4;

  localparam logic [7:0] CHAR_NL      = 8'h0A;
  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_ZERO    = 8'h30;
  localparam logic [7:0] CHAR_NINE    = 8'h39;
  localparam logic [7:0] DEF_END_CHAR = 8'h04;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_SHORT   = 1;
  localparam int ERR_LONG    = 2;
  localparam int NERR        = 3;

  typedef enum logic [1:0] {
    IDLE,
    IN_BANK,
    EMIT_END,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_DIGIT,
    CLS_NL,
    CLS_CR,
    CLS_END,
    CLS_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic [JW-1:0] jolt;
    logic          valid;
    logic          bank_end;
    logic          eop;
  } beat_t;

endpackage

// File: rtl/joltage_stream_tx_if.sv
// Byte-in / beat-out bundle of the joltage stream producer.
// The master drives bytes and observes beats; the slave is the producer.
interface joltage_stream_tx_if;
  import joltage_pkg::*;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [JW-1:0] joltage_out;
  logic          joltage_out_valid;
  logic          bank_end;
  logic          end_of_puzzle_tx;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  joltage_out,
    input  joltage_out_valid,
    input  bank_end,
    input  end_of_puzzle_tx
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output joltage_out,
    output joltage_out_valid,
    output bank_end,
    output end_of_puzzle_tx
  );

endinterface

// File: rtl/joltage_stream_tx_classifier.sv
// Maps one ASCII byte to its class and digit value.
// The end character wins over every other class.
module ascii_char_classifier
  import joltage_pkg::*;
#(
  parameter logic [7:0] END_CHAR = DEF_END_CHAR
) (
  input  logic [7:0]    char_i,
  output cls_e          cls_o,
  output logic [JW-1:0] val_o
);

  logic is_end;
  logic is_dig;
  logic is_nl;
  logic is_cr;

  always_comb begin
    is_end = (char_i == END_CHAR);
    is_dig = !is_end
           && (char_i > CHAR_ZERO)
           && (char_i <= CHAR_NINE);
    is_nl  = !is_end && (char_i == CHAR_NL);
    is_cr  = !is_end && (char_i == CHAR_CR);
  end

  always_comb begin
    cls_o = CLS_ILLEGAL;
    val_o = '0;
    unique case (1'b1)
      is_end: cls_o = CLS_END;
      is_dig: begin
        cls_o = CLS_DIGIT;
        val_o = char_i[JW-1:0];
      end
      is_nl:  cls_o = CLS_NL;
      is_cr:  cls_o = CLS_CR;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/joltage_stream_tx.sv
// Turns the ASCII puzzle stream into registered joltage beats,
// bank-end markers and a final end-of-puzzle beat.
module joltage_stream_tx
  import joltage_pkg::*;
#(
  parameter logic [7:0] END_CHAR        = DEF_END_CHAR,
  parameter int         MAX_BANK_DIGITS = 100
) (
  input  logic            clk,
  input  logic            reset,
  joltage_stream_tx_if.slave bus,
  output logic [15:0]     bank_count,
  output logic [NERR-1:0] parse_error,
  output logic            done
);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      cnt_inc;
  beat_t           beat_q, beat_d;
  logic [15:0]     bc_q, bc_d;
  logic [NERR-1:0] err_q, err_d;
  logic            done_q, done_d;
  logic            rdy_q, rdy_d;
  logic            accept;
  cls_e            cls;
  logic [JW-1:0]   val;

  ascii_char_classifier #(
    .END_CHAR(END_CHAR)
  ) u_cls (
    .char_i(bus.rx_data),
    .cls_o (cls),
    .val_o (val)
  );

  assign accept  = bus.rx_valid & rdy_q;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = '0;
    bc_d    = bc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cls)
            CLS_DIGIT: begin
              beat_d.jolt  = val;
              beat_d.valid = 1'b1;
              cnt_d        = 8'd1;
              state_d      = IN_BANK;
            end
            CLS_END: begin
              beat_d.valid = 1'b1;
              beat_d.eop   = 1'b1;
              state_d      = DONE;
            end
            CLS_ILLEGAL: err_d[ERR_ILLEGAL] = 1'b1;
            default: ;
          endcase
        end
      end
      IN_BANK: begin
        if (accept) begin
          unique case (cls)
            CLS_DIGIT: begin
              beat_d.jolt  = val;
              beat_d.valid = 1'b1;
              cnt_d        = cnt_inc;
              if (int'(cnt_inc) > MAX_BANK_DIGITS)
                err_d[ERR_LONG] = 1'b1;
            end
            CLS_NL, CLS_END: begin
              // EOT closes the open bank first; the end beat follows
              beat_d.valid    = 1'b1;
              beat_d.bank_end = 1'b1;
              bc_d            = bc_q + 16'd1;
              cnt_d           = '0;
              if (cnt_q < 8'd2)
                err_d[ERR_SHORT] = 1'b1;
              state_d = (cls == CLS_END) ? EMIT_END : IDLE;
            end
            CLS_ILLEGAL: err_d[ERR_ILLEGAL] = 1'b1;
            default: ;
          endcase
        end
      end
      EMIT_END: begin
        beat_d.valid = 1'b1;
        beat_d.eop   = 1'b1;
        state_d      = DONE;
      end
      DONE: ;
    endcase
  end

  always_comb begin
    rdy_d  = (state_d == IDLE) || (state_d == IN_BANK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      bc_q    <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      bc_q    <= bc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.rx_ready          = rdy_q;
  assign bus.joltage_out       = beat_q.jolt;
  assign bus.joltage_out_valid = beat_q.valid;
  assign bus.bank_end          = beat_q.bank_end;
  assign bus.end_of_puzzle_tx  = beat_q.eop;
  assign bank_count            = bc_q;
  assign parse_error           = err_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_joltage_stream_tx.sv
// Directed and random byte streams against a queue-based model
// of the expected beats, their cycles and the status outputs.
module tb_joltage_stream_tx;
  import joltage_pkg::*;

  typedef logic [24:0] rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bank_count;
  logic [2:0]  parse_error;
  logic        done;

  joltage_stream_tx_if bus();

  joltage_stream_tx #(
    .END_CHAR       (8'h04),
    .MAX_BANK_DIGITS(100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .bank_count (bank_count),
    .parse_error(parse_error),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  rec_t got_q[$];
  int   got_c[$];

  always @(negedge clk) begin
    if (bus.joltage_out_valid === 1'b1) begin
      got_q.push_back({bank_count, parse_error,
                       bus.end_of_puzzle_tx, bus.bank_end,
                       bus.joltage_out});
      got_c.push_back(cyc);
    end
    chk("flags_exclusive",
        32'(bus.bank_end & bus.end_of_puzzle_tx), 32'd0);
    chk("quiet_when_invalid",
        bus.joltage_out_valid ? 32'd0 :
        32'({bus.joltage_out, bus.bank_end, bus.end_of_puzzle_tx}),
        32'd0);
  end

  logic [7:0]  stim[$];
  logic [7:0]  sent_b[$];
  int          sent_c[$];
  rec_t        exp_q[$];
  int          exp_c[$];
  logic [15:0] m_bc;
  logic [2:0]  m_pe;
  logic        m_done;

  task automatic load(string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  // Expected beats from the stream rules, timed from each acceptance
  task automatic model();
    int n = 0;
    bit open = 0;
    exp_q.delete(); exp_c.delete();
    m_bc = 0; m_pe = 0; m_done = 0;
    for (int i = 0; i < sent_b.size(); i++) begin
      logic [7:0] b = sent_b[i];
      int t = sent_c[i] + 1;
      if (b == 8'h04) begin
        if (open) begin
          m_bc++;
          if (n < 2) m_pe[1] = 1'b1;
          exp_q.push_back({m_bc, m_pe, 2'b01, 4'd0});
          exp_c.push_back(t);
          t++;
        end
        exp_q.push_back({m_bc, m_pe, 2'b10, 4'd0});
        exp_c.push_back(t);
        m_done = 1'b1;
        break;
      end else if (b >= 8'h31 && b <= 8'h39) begin
        n = (n < 255) ? n + 1 : 255;
        if (n > 100) m_pe[2] = 1'b1;
        open = 1;
        exp_q.push_back({m_bc, m_pe, 2'b00, 4'(b - 8'h30)});
        exp_c.push_back(t);
      end else if (b == 8'h0A) begin
        if (open) begin
          m_bc++;
          if (n < 2) m_pe[1] = 1'b1;
          exp_q.push_back({m_bc, m_pe, 2'b01, 4'd0});
          exp_c.push_back(t);
          n = 0;
          open = 0;
        end
      end else if (b != 8'h0D) begin
        m_pe[0] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_case(string name, bit rst, bit gaps);
    int tries;
    int k;
    if (rst) do_reset();
    got_q.delete(); got_c.delete();
    sent_b.delete(); sent_c.delete();
    foreach (stim[i]) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
      tries = 0;
      while (bus.rx_ready !== 1'b1 && tries < 20) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
        tries++;
      end
      if (bus.rx_ready !== 1'b1) begin
        chk({name, " rx_ready_timeout"}, 32'(bus.rx_ready), 32'd1);
        break;
      end
      bus.rx_data  = stim[i];
      bus.rx_valid = 1'b1;
      sent_b.push_back(stim[i]);
      sent_c.push_back(cyc);
      if (stim[i] == 8'h04) break;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    model();
    chk({name, " beat_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    k = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < k; i++) begin
      chk($sformatf("%s beat%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s cycle%0d", name, i), 32'(got_c[i]), 32'(exp_c[i]));
    end
    chk({name, " bank_count"}, 32'(bank_count), 32'(m_bc));
    chk({name, " parse_error"}, 32'(parse_error), 32'(m_pe));
    chk({name, " done"}, 32'(done), 32'(m_done));
    chk({name, " rx_ready"}, 32'(bus.rx_ready), 32'(!m_done));
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("reset valid", 32'(bus.joltage_out_valid), 32'd0);
    chk("reset bank_count", 32'(bank_count), 32'd0);
    chk("reset parse_error", 32'(parse_error), 32'd0);
    chk("reset done", 32'(done), 32'd0);

    load("98\n\004");
    run_case("t98", 1, 0);

    load("12\r\n\n34\004");
    run_case("t12_34", 1, 0);

    load("5\n");
    run_case("short", 1, 0);
    chk("short err", 32'(parse_error), 32'h2);

    load("1x02\n");
    run_case("illegal", 1, 0);
    chk("illegal err0", 32'(parse_error[0]), 32'd1);

    stim.delete();
    repeat (101) stim.push_back(8'h37);
    stim.push_back(8'h0A);
    run_case("long", 1, 0);
    chk("long err2", 32'(parse_error[2]), 32'd1);

    do_reset();
    @(negedge clk);
    bus.rx_data  = 8'h39;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("rstmid beat9",
        32'({bus.joltage_out_valid, bus.joltage_out}), 32'h19);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete(); got_c.delete();
    chk("rstmid rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rstmid valid", 32'(bus.joltage_out_valid), 32'd0);
    chk("rstmid bank_count", 32'(bank_count), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid no_beats", 32'(got_q.size()), 32'd0);
    load("11\n");
    run_case("after_rst", 0, 0);

    for (int r = 0; r < 8; r++) begin
      int len = $urandom_range(5, 60);
      stim.delete();
      for (int j = 0; j < len; j++) begin
        int p = $urandom_range(0, 19);
        if (p < 12)       stim.push_back(8'(8'h31 + $urandom_range(0, 8)));
        else if (p < 15)  stim.push_back(8'h0A);
        else if (p == 15) stim.push_back(8'h0D);
        else if (p == 16) stim.push_back(8'h30);
        else if (p == 17) stim.push_back(8'h78);
        else              stim.push_back(8'(8'h31 + $urandom_range(0, 8)));
      end
      if (r % 2 == 0) stim.push_back(8'h04);
      run_case($sformatf("rand%0d", r), 1, r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
